// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 active-low keypad matrix one row at a time, synchronises and
//   debounces the column returns, and reports each accepted press exactly once.
//
// Ports
//   clk        system clock (low-frequency oscillator)
//   resetn     asynchronous active-low reset
//   col_in     keypad columns, pulled up; a pressed key on the driven row pulls its column low
//   row_out    keypad rows, active-low, exactly one row driven at a time
//   key_code   code of the last accepted key, held until the next accepted key
//   key_valid  one-cycle pulse in the cycle key_code takes a new value
//   key_held   high while the accepted key is still pressed (until release is debounced)

module keypad_scanner #(
    parameter int SCAN_DIV   = 16,  // cycles each row is driven before it is sampled (>= 4)
    parameter int DEBOUNCE_N = 4    // identical samples needed to accept a press or release (>= 2)
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_N + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_N - 1);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    col_meta, col_s;
    logic [DW-1:0] dwell_q;
    logic [1:0]    row_q, row_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    key_col_q, key_col_d;
    logic [3:0]    code_d;
    logic          valid_d, held_d;

    logic          sample;
    logic [2:0]    low_cnt;
    logic [1:0]    low_col;
    logic          single;

    // Key legend: A/B/C/D = + - x /, E = clear (*), F = equals (#).
    function automatic logic [3:0] map_key(input logic [1:0] row, input logic [1:0] col);
        case ({row, col})
            4'h0: map_key = 4'h1;
            4'h1: map_key = 4'h2;
            4'h2: map_key = 4'h3;
            4'h3: map_key = 4'hA;
            4'h4: map_key = 4'h4;
            4'h5: map_key = 4'h5;
            4'h6: map_key = 4'h6;
            4'h7: map_key = 4'hB;
            4'h8: map_key = 4'h7;
            4'h9: map_key = 4'h8;
            4'hA: map_key = 4'h9;
            4'hB: map_key = 4'hC;
            4'hC: map_key = 4'hE;
            4'hD: map_key = 4'h0;
            4'hE: map_key = 4'hF;
            4'hF: map_key = 4'hD;
        endcase
    endfunction

    // Two-flop synchroniser; columns idle high, so reset to "no key".
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge value of its source regardless of process evaluation order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            col_meta <= 4'hF;
            col_s    <= 4'hF;
        end else begin
            col_meta <= col_in;
            col_s    <= col_meta;
        end
    end

    // Free-running dwell counter; its last count is the only decision point.
    assign sample = (dwell_q == DWELL_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)     dwell_q <= '0;
        else if (sample) dwell_q <= '0;
        else             dwell_q <= dwell_q + DW'(1);
    end

    // Exactly one low column is a key; several low columns are rejected.
    always_comb begin
        low_cnt = '0;
        low_col = '0;
        for (int i = 0; i < 4; i++) begin
            if (!col_s[i]) begin
                low_cnt = low_cnt + 3'd1;
                low_col = 2'(i);
            end
        end
    end

    assign single  = (low_cnt == 3'd1);
    assign row_out = ~(4'b0001 << row_q);

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        cnt_d     = cnt_q;
        key_col_d = key_col_q;
        code_d    = key_code;
        valid_d   = 1'b0;
        held_d    = key_held;

        if (sample) begin
            case (state_q)
                SCAN: begin
                    if (single) begin
                        key_col_d = low_col;
                        cnt_d     = CW'(1);
                        state_d   = DEBOUNCE;
                    end else begin
                        row_d = row_q + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (single && low_col == key_col_q) begin
                        // The Nth agreeing sample commits the key on this edge,
                        // so the strobe appears in the following cycle.
                        if (cnt_q == CNT_LAST) begin
                            code_d  = map_key(row_q, key_col_q);
                            valid_d = 1'b1;
                            held_d  = 1'b1;
                            cnt_d   = '0;
                            state_d = HELD;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else begin
                        cnt_d   = '0;
                        row_d   = row_q + 2'd1;
                        state_d = SCAN;
                    end
                end
                HELD: begin
                    // Release needs every column high: a second key held on this
                    // row keeps the first one "held" until both are let go.
                    if (col_s == 4'hF) begin
                        if (cnt_q == CNT_LAST) begin
                            held_d  = 1'b0;
                            cnt_d   = '0;
                            row_d   = row_q + 2'd1;
                            state_d = SCAN;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= SCAN;
            row_q     <= 2'd0;
            cnt_q     <= '0;
            key_col_q <= 2'd0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            cnt_q     <= cnt_d;
            key_col_q <= key_col_d;
            key_code  <= code_d;
            key_valid <= valid_d;
            key_held  <= held_d;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
//   Emulates a physical 4x4 keypad around keypad_scanner and compares every
//   output, every cycle, against a behavioural model of the scanner, plus
//   directed checks of reset values, latency and release timing.

module tb_keypad_scanner;

    localparam int SCAN_DIV   = 16;
    localparam int DEBOUNCE_N = 4;
    localparam int M_SCAN = 0, M_DEB = 1, M_HELD = 2;

    logic       clk;
    logic       resetn;
    logic [3:0] col_in;
    logic [3:0] row_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    keypad_scanner #(
        .SCAN_DIV  (SCAN_DIV),
        .DEBOUNCE_N(DEBOUNCE_N)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .col_in   (col_in),
        .row_out  (row_out),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical keypad: bit r*4+c closes the switch between row r and column c.
    logic [15:0] keys;
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int pulses = 0;
    int first  = -1;

    // Reference model state
    int         keymap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
    logic [3:0] m_s1, m_s2;
    int         m_phase, m_row, m_mode, m_run, m_col;
    logic [3:0] m_code;
    logic       m_valid, m_held;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = 4'hF; m_s2 = 4'hF;
        m_phase = 0; m_row = 0; m_mode = M_SCAN; m_run = 0; m_col = 0;
        m_code = 4'h0; m_valid = 1'b0; m_held = 1'b0;
    endtask

    // One clock edge of the model; cin is the column value just before the edge.
    task automatic model_edge(input logic [3:0] cin);
        int zeros, zcol;
        if (!resetn) begin
            model_reset();
            return;
        end
        m_valid = 1'b0;
        if (m_phase == SCAN_DIV - 1) begin
            zeros = $countones(~m_s2);
            zcol  = 0;
            for (int c = 0; c < 4; c++) if (!m_s2[c]) zcol = c;
            if (m_mode == M_SCAN) begin
                if (zeros == 1) begin
                    m_mode = M_DEB; m_col = zcol; m_run = 1;
                end else begin
                    m_row = (m_row + 1) % 4;
                end
            end else if (m_mode == M_DEB) begin
                if (zeros == 1 && zcol == m_col) begin
                    m_run++;
                    if (m_run == DEBOUNCE_N) begin
                        m_code = 4'(keymap[m_row*4 + m_col]);
                        m_valid = 1'b1; m_held = 1'b1; m_run = 0; m_mode = M_HELD;
                    end
                end else begin
                    m_run = 0; m_row = (m_row + 1) % 4; m_mode = M_SCAN;
                end
            end else begin
                if (m_s2 == 4'hF) begin
                    m_run++;
                    if (m_run == DEBOUNCE_N) begin
                        m_held = 1'b0; m_run = 0; m_row = (m_row + 1) % 4; m_mode = M_SCAN;
                    end
                end else begin
                    m_run = 0;
                end
            end
        end
        m_phase = (m_phase + 1) % SCAN_DIV;
        m_s2 = m_s1;
        m_s1 = cin;
    endtask

    task automatic compare_all();
        logic [3:0] er;
        er = 4'hF;
        er[m_row] = 1'b0;
        check("row_out", row_out, er);
        check("key_code", key_code, m_code);
        check("key_valid", {3'b000, key_valid}, {3'b000, m_valid});
        check("key_held", {3'b000, key_held}, {3'b000, m_held});
    endtask

    task automatic tick();
        logic [3:0] c_pre;
        @(posedge clk);
        c_pre = col_in;
        model_edge(c_pre);
        #1;
        cyc++;
        if (key_valid === 1'b1) begin
            pulses++;
            if (first < 0) first = cyc;
        end
        compare_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_row"}, row_out, 4'b1110);
        check({tag, "_code"}, key_code, 4'h0);
        check({tag, "_valid"}, {3'b000, key_valid}, 4'h0);
        check({tag, "_held"}, {3'b000, key_held}, 4'h0);
    endtask

    // Called just after a clock edge; leaves reset released mid-cycle with cyc=0.
    task automatic do_reset(input string tag);
        resetn = 1'b0;
        model_reset();
        #1;
        check_reset_values(tag);
        ticks(3);
        resetn = 1'b1;
        cyc = 0; pulses = 0; first = -1;
    endtask

    task automatic wait_debounce(input int target, input int bound);
        int n;
        n = 0;
        while (!(m_mode == M_DEB && m_run == target) && n < bound) begin
            tick();
            n++;
        end
        check_int("wait_debounce_in_time", int'(n < bound), 1);
    endtask

    initial begin
        logic [3:0] rows [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [3:0] prev_row, next_row;
        bit         got;
        int         n;

        keys   = '0;
        resetn = 1'b0;
        model_reset();
        #2;

        // 1. Reset values and idle row rotation
        do_reset("reset");
        for (int i = 0; i < 80; i++) begin
            check("idle_rows", row_out, rows[(i / SCAN_DIV) % 4]);
            tick();
        end

        // 2. Single press of '5' from a fresh reset
        do_reset("reset2");
        keys[1*4+1] = 1'b1;
        ticks(500);
        check_int("press5_latency", first, 31 + (DEBOUNCE_N - 1) * SCAN_DIV + 1);
        check_int("press5_pulses", pulses, 1);
        check("press5_code", key_code, 4'h5);
        check("press5_held", {3'b000, key_held}, 4'h1);
        check("press5_row", row_out, 4'b1101);
        keys = '0;
        n = 0;
        while (key_held === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check_int("press5_release_window", int'(n >= 51 && n <= 67), 1);

        // 3. Bounce on row 3: only two agreeing samples
        keys[3*4+2] = 1'b1;
        wait_debounce(2, 200);
        keys = '0;
        pulses = 0;
        prev_row = row_out;
        next_row = 4'h0;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!got && row_out !== prev_row) begin
                got = 1'b1;
                next_row = row_out;
            end
        end
        check_int("bounce_pulses", pulses, 0);
        check("bounce_code_kept", key_code, 4'h5);
        check("bounce_next_row", next_row, 4'b1110);

        // 4. Multi-key on row 0 rejected, then single 'A' accepted
        keys = '0;
        keys[0] = 1'b1;
        keys[3] = 1'b1;
        pulses = 0;
        ticks(200);
        check_int("multi_pulses", pulses, 0);
        check("multi_held", {3'b000, key_held}, 4'h0);
        keys[0] = 1'b0;
        ticks(300);
        check_int("keyA_pulses", pulses, 1);
        check("keyA_code", key_code, 4'hA);
        keys = '0;
        ticks(100);
        check("keyA_released", {3'b000, key_held}, 4'h0);

        // 5. '#' then '0', with '0' also pressed while '#' is held
        pulses = 0;
        keys[3*4+2] = 1'b1;
        ticks(300);
        check_int("hash_pulses", pulses, 1);
        check("hash_code", key_code, 4'hF);
        keys[3*4+1] = 1'b1;
        ticks(200);
        check_int("hash_plus_zero_pulses", pulses, 1);
        check("hash_still_held", {3'b000, key_held}, 4'h1);
        keys[3*4+1] = 1'b0;
        ticks(50);
        keys = '0;
        ticks(100);
        check("hash_released", {3'b000, key_held}, 4'h0);
        keys[3*4+1] = 1'b1;
        ticks(300);
        check_int("zero_pulses", pulses, 2);
        check("zero_code", key_code, 4'h0);
        keys = '0;
        ticks(100);

        // 6. Asynchronous reset in the middle of a debounce of '8'
        keys[2*4+1] = 1'b1;
        wait_debounce(2, 300);
        ticks(5);
        #3;
        resetn = 1'b0;
        model_reset();
        #1;
        check_reset_values("midreset");
        ticks(3);
        resetn = 1'b1;
        cyc = 0; pulses = 0; first = -1;
        ticks(300);
        check_int("after_reset_pulses", pulses, 1);
        check_int("after_reset_latency", first, 47 + (DEBOUNCE_N - 1) * SCAN_DIV + 1);
        check("after_reset_code", key_code, 4'h8);
        keys = '0;
        ticks(100);

        // 7. Random presses, occasionally with a second key, random hold/gap lengths
        for (int it = 0; it < 25; it++) begin
            keys = '0;
            keys[$urandom_range(0, 15)] = 1'b1;
            if ($urandom_range(0, 3) == 0) keys[$urandom_range(0, 15)] = 1'b1;
            ticks($urandom_range(0, 400));
            keys = '0;
            ticks($urandom_range(0, 150));
        end
        ticks(100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
